secure_sram_host_ctrl: RTL
==========================

Name: secure_sram_host_ctrl

Overview:
Initiator-side controller that drives the secure SRAM access port: chip select, write enable, address, write data, the data corruption request (dcr) and the TRNG key inputs.
- Accepts read/write requests on a valid/ready channel and tracks the fixed read latency.
- Returns read data in order through a credit-limited response FIFO.
- Runs a drain-then-rekey sequence so the TRNG key never changes while a read is inside the SRAM pipeline.
- Sits between the system bus adapter and secure_sram_top.

Parameters:
ADDR_WIDTH, 14, SRAM word address width
DATA_WIDTH, 52, data word width
TRNG_A_WIDTH, 64, address-mapping key width
TRNG_D_WIDTH, 32, data-mapping key width
READ_LATENCY, 2, cycles from sram_cs (read) high to valid sram_rdata
RSP_DEPTH, 4, response FIFO depth and read credit limit (power of 2)
SETTLE_CYCLES, 2, idle cycles after dcr before traffic resumes

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  logical address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer pops on valid&ready
rsp_data  out  DATA_WIDTH  read data, FIFO head
rekey_req  in  1  one-cycle pulse requesting key rotation
rekey_busy  out  1  high in DRAIN/REKEY/SETTLE
rekey_done  out  1  one-cycle pulse when rotation completes
trng_a_src  in  TRNG_A_WIDTH  fresh address key from TRNG
trng_d_src  in  TRNG_D_WIDTH  fresh data key from TRNG
sram_cs, sram_we  out  1  to SRAM cs/we
sram_addr  out  ADDR_WIDTH  to SRAM addr
sram_wdata  out  DATA_WIDTH  to SRAM wdata
sram_dcr  out  1  to SRAM dcr
sram_trng_a  out  TRNG_A_WIDTH  to SRAM trng_a_in
sram_trng_d  out  TRNG_D_WIDTH  to SRAM trng_d_in
sram_rdata  in  DATA_WIDTH  from SRAM rdata

Behaviour:
- Interface decision: one clock clk; reset rst is synchronous, active-high.
- Reset: all outputs 0; FSM returns to IDLE; FIFO emptied; credit counter 0; read-tracking shift register cleared. Reset takes priority in any state, including mid-DRAIN.
- req_ready = (state==IDLE) && (credits < RSP_DEPTH). It does not depend on req_valid, and writes are gated the same way.
- Issue: a handshake at edge N registers sram_cs=1, sram_we=req_we, sram_addr and sram_wdata for exactly cycle N+1. sram_cs returns to 0 when no handshake occurs.
- Credits: +1 on an accepted read, -1 on a response pop. Both in the same cycle leaves the count unchanged.
- Read tracking: a READ_LATENCY-deep valid shift register.
  - Sampled sram_rdata is pushed into the FIFO in cycle N+1+READ_LATENCY.
  - rsp_valid rises in cycle N+2+READ_LATENCY, i.e. 4 cycles after the handshake with defaults.
  - The FIFO cannot overflow by construction; responses are in order.
- FSM: IDLE -> DRAIN -> REKEY -> SETTLE -> IDLE.
  - IDLE: on rekey_req, go to DRAIN. A request handshake in the same cycle is still accepted.
  - DRAIN: req_ready=0. Wait until the read shift register is empty and no issue is pending; the FIFO contents may remain. Then go to REKEY.
  - REKEY (1 cycle): sram_dcr=1. sram_trng_a/d registers load trng_a_src/d_src captured on DRAIN exit and hold those values until the next rotation. Then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to IDLE and pulse rekey_done in the first IDLE cycle.
- rekey_req while rekey_busy=1 is ignored (not queued).
- rsp_ready is honoured in every state.

Optional Feature:
SECURE_SRAM_HOST_STATS_EN
- Defined: adds outputs stat_rd_cnt, stat_wr_cnt and stat_rekey_cnt, each 32-bit. They count accepted reads, accepted writes and completed rotations, wrap at 2^32 and clear on rst.
- Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Package secure_sram_host_pkg: FSM state enum (IDLE, DRAIN, REKEY, SETTLE), STAT_WIDTH=32, credit-counter width function.
- One sub-module, sram_rsp_fifo: synchronous FIFO with parameters DEPTH and WIDTH, ports push/pop/full/empty/count, registered head output.

Test Plan:
1. Write addr 0x0010 data 0x0ABCDEF012345, then read 0x0010 -> rsp_data=0x0ABCDEF012345; rsp_valid exactly 4 cycles after the read handshake; sram_cs high exactly 1 cycle per request.
2. rsp_ready=0, 6 back-to-back reads -> 4 accepted, then req_ready=0; release rsp_ready -> 4 responses in issue order; req_ready reasserts after the first pop.
3. Two reads in flight, then rekey_req with trng_a_src=0x0123456789ABCDEF, trng_d_src=0xDEADBEEF -> sram_dcr asserts only after both reads are pushed, for 1 cycle; sram_trng_a/d equal these values; rekey_done pulses 1+SETTLE_CYCLES cycles after dcr; a read of the old address returns a value differing from the data written.
4. rekey_req and req_valid read in the same cycle -> the read is accepted and completes before sram_dcr; a second rekey_req during SETTLE is ignored (one rekey_done only).
5. rst=1 during DRAIN with 1 read outstanding -> next cycle all outputs 0, rsp_valid=0, rekey_busy=0, req_ready=1.
6. With SECURE_SRAM_HOST_STATS_EN: 3 writes, 5 reads, 1 rekey -> stat_wr_cnt=3, stat_rd_cnt=5, stat_rekey_cnt=1.

Source files
------------

// File: rtl/secure_sram_host_pkg.sv
// Shared types and helpers for the secure SRAM host controller.
// Optional statistics counters are enabled with SECURE_SRAM_HOST_STATS_EN.
package secure_sram_host_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REKEY  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int STAT_WIDTH = 32;

    // Width needed to hold a credit count from 0 up to and including depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with a registered head word.
// DEPTH must be a power of two (at least 2); push when full and pop when empty are ignored.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 52,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage array write port; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Head follows the next stored word, or bypasses the incoming word
            // when it becomes the only entry.
            if (pop_ok) begin
                if (count > CNT_W'(1)) begin
                    head <= mem[rd_ptr + AW'(1)];
                end else if (push_ok) begin
                    head <= push_data;
                end
            end else if (empty && push_ok) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/secure_sram_host_ctrl.sv
// Initiator-side controller for the secure SRAM: request issue, read-latency
// tracking, in-order credit-limited responses and drain-then-rekey sequencing.
// Define SECURE_SRAM_HOST_STATS_EN to add read/write/rotation statistics outputs.
module secure_sram_host_ctrl
    import secure_sram_host_pkg::*;
#(
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 52,
    parameter int TRNG_A_WIDTH  = 64,
    parameter int TRNG_D_WIDTH  = 32,
    parameter int READ_LATENCY  = 2,
    parameter int RSP_DEPTH     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic                    rekey_req,
    output logic                    rekey_busy,
    output logic                    rekey_done,
    input  logic [TRNG_A_WIDTH-1:0] trng_a_src,
    input  logic [TRNG_D_WIDTH-1:0] trng_d_src,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    output logic                    sram_dcr,
    output logic [TRNG_A_WIDTH-1:0] sram_trng_a,
    output logic [TRNG_D_WIDTH-1:0] sram_trng_d,
`ifdef SECURE_SRAM_HOST_STATS_EN
    output logic [STAT_WIDTH-1:0]   stat_rd_cnt,
    output logic [STAT_WIDTH-1:0]   stat_wr_cnt,
    output logic [STAT_WIDTH-1:0]   stat_rekey_cnt,
`endif
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    localparam int CW = credit_width(RSP_DEPTH);
    // SETTLE_CYCLES is expected to be at least 1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                  state;
    logic [CW-1:0]           credits;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [SW-1:0]           settle_cnt;
    logic                    hs;
    logic                    rd_acc;
    logic                    rsp_pop;
    logic                    fifo_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;

    // Credits count reads issued but not yet consumed, so the FIFO never overflows.
    assign req_ready  = (state == IDLE) && (credits < CW'(RSP_DEPTH));
    assign hs         = req_valid & req_ready;
    assign rd_acc     = hs & ~req_we;
    assign rsp_pop    = rsp_ready & ~fifo_empty;
    assign rsp_valid  = (fifo_count != '0);
    assign fifo_push  = rd_pipe[READ_LATENCY-1] & ~fifo_full;
    assign rekey_busy = (state != IDLE);

    // Drive the SRAM port for exactly one cycle per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_cs <= hs;
            sram_we <= hs & req_we;
            if (hs) begin
                sram_addr  <= req_addr;
                sram_wdata <= req_wdata;
            end
        end
    end

    // Track each read through the SRAM pipeline; the last stage marks valid rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= sram_cs & ~sram_we;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Read credit accounting: take on read accept, return on response pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({rd_acc, rsp_pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Rekey sequencer: keys only change once no read is inside the SRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            sram_dcr    <= 1'b0;
            sram_trng_a <= '0;
            sram_trng_d <= '0;
            rekey_done  <= 1'b0;
        end else begin
            sram_dcr   <= 1'b0;
            rekey_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rekey_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A request accepted on the entry edge is still on the port here.
                    if (!(|rd_pipe) && !sram_cs) begin
                        state       <= REKEY;
                        sram_dcr    <= 1'b1;
                        sram_trng_a <= trng_a_src;
                        sram_trng_d <= trng_d_src;
                    end
                end
                REKEY: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state      <= IDLE;
                        rekey_done <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sram_rdata),
        .pop       (rsp_pop),
        .head      (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef SECURE_SRAM_HOST_STATS_EN
    // Free-running wrap-around counters of accepted traffic and finished rotations.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_rekey_cnt <= '0;
        end else begin
            if (rd_acc) begin
                stat_rd_cnt <= stat_rd_cnt + STAT_WIDTH'(1);
            end
            if (hs && req_we) begin
                stat_wr_cnt <= stat_wr_cnt + STAT_WIDTH'(1);
            end
            if ((state == SETTLE) && (settle_cnt == SW'(SETTLE_CYCLES - 1))) begin
                stat_rekey_cnt <= stat_rekey_cnt + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
